// File: rtl/synth_pkg.sv
// Shared definitions for the I2C arbiter: master status codes, FSM states
// and parameter defaults.
package synth_pkg;

    localparam int N_REQ_DEFAULT   = 4;
    localparam int TIMEOUT_DEFAULT = 4096;

    localparam logic [1:0] I2C_IDLE  = 2'b00;
    localparam logic [1:0] I2C_BUSY  = 2'b01;
    localparam logic [1:0] I2C_DONE  = 2'b10;
    localparam logic [1:0] I2C_ERROR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_RESP
    } arb_state_e;

    // Index width that stays legal for a single requester.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr,
// returned both one-hot and as a binary index.
module rr_arbiter
    import synth_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT,
    parameter int PTR_W = ptr_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [PTR_W-1:0] gnt_idx
);
    logic             found;
    logic [PTR_W-1:0] pos;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        pos     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = PTR_W'((int'(ptr) + k) % N_REQ);
            if (!found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                gnt_idx  = pos;
            end
        end
    end

endmodule

// File: rtl/i2c_arbiter.sv
// Shares one I2C master between N_REQ requesters, one transaction at a time.
// The winner's fields are latched at grant so the master sees stable inputs.
module i2c_arbiter
    import synth_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [7*N_REQ-1:0] req_dev_addr,
    input  logic [N_REQ-1:0]   req_rw,
    input  logic [8*N_REQ-1:0] req_reg_addr,
    input  logic [8*N_REQ-1:0] req_wdata,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   done,
    output logic               err,
    output logic [7:0]         rdata,
    output logic [8:0]         i2c_dev_addr,
    output logic [7:0]         i2c_reg_addr,
    output logic [7:0]         i2c_wdata,
    input  logic [7:0]         i2c_rdata,
    input  logic               i2c_we,
    input  logic [1:0]         i2c_status
);
    localparam int PTR_W = ptr_width(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT);

    logic [6:0] dev_arr [N_REQ];
    logic [7:0] reg_arr [N_REQ];
    logic [7:0] wd_arr  [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign dev_arr[gi] = req_dev_addr[gi*7 +: 7];
        assign reg_arr[gi] = req_reg_addr[gi*8 +: 8];
        assign wd_arr[gi]  = req_wdata[gi*8 +: 8];
    end

    logic [N_REQ-1:0] pick_gnt;
    logic [PTR_W-1:0] pick_idx;

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic             go_q, go_d;
    logic             err_q, err_d;
    logic [7:0]       rdata_q, rdata_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       dev_q, dev_d;
    logic             rw_q, rw_d;
    logic [7:0]       reg_q, reg_d;
    logic [7:0]       wd_q, wd_d;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req     (req),
        .ptr     (ptr_q),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        go_d    = go_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        dev_d   = dev_q;
        rw_d    = rw_q;
        reg_d   = reg_q;
        wd_d    = wd_q;

        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    state_d = S_LAUNCH;
                    gnt_d   = pick_gnt;
                    idx_d   = pick_idx;
                    go_d    = 1'b1;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    dev_d   = dev_arr[pick_idx];
                    rw_d    = req_rw[pick_idx];
                    reg_d   = reg_arr[pick_idx];
                    wd_d    = wd_arr[pick_idx];
                end
            end
            S_LAUNCH, S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (i2c_we) begin
                    rdata_d = i2c_rdata;
                end
                // A real completion status wins over a simultaneous timeout.
                if (state_q == S_WAIT &&
                    (i2c_status == I2C_DONE || i2c_status == I2C_ERROR)) begin
                    state_d = S_RESP;
                    done_d  = gnt_q;
                    err_d   = (i2c_status == I2C_ERROR);
                    go_d    = 1'b0;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = S_RESP;
                    done_d  = gnt_q;
                    err_d   = 1'b1;
                    go_d    = 1'b0;
                end else if (state_q == S_LAUNCH && i2c_status == I2C_BUSY) begin
                    state_d = S_WAIT;
                    go_d    = 1'b0;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                err_d   = 1'b0;
                cnt_d   = '0;
                ptr_d   = (idx_q == PTR_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            go_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            ptr_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            dev_q   <= '0;
            rw_q    <= 1'b0;
            reg_q   <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            go_q    <= go_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            dev_q   <= dev_d;
            rw_q    <= rw_d;
            reg_q   <= reg_d;
            wd_q    <= wd_d;
        end
    end

    assign gnt          = gnt_q;
    assign done         = done_q;
    assign err          = err_q;
    assign rdata        = rdata_q;
    assign i2c_dev_addr = {go_q, dev_q, rw_q};
    assign i2c_reg_addr = reg_q;
    assign i2c_wdata    = wd_q;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed bench for i2c_arbiter: vector table for write/read flows plus
// hand sequences for NACK, stability, contention, timeout and reset.
module tb_i2c_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] req;
    logic [7*N-1:0] req_dev_addr;
    logic [N-1:0] req_rw;
    logic [8*N-1:0] req_reg_addr;
    logic [8*N-1:0] req_wdata;
    logic [N-1:0] gnt;
    logic [N-1:0] done;
    logic         err;
    logic [7:0]   rdata;
    logic [8:0]   i2c_dev_addr;
    logic [7:0]   i2c_reg_addr;
    logic [7:0]   i2c_wdata;
    logic [7:0]   i2c_rdata;
    logic         i2c_we;
    logic [1:0]   i2c_status;

    int tests = 0;
    int fails = 0;

    i2c_arbiter #(.N_REQ(N), .TIMEOUT(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_dev_addr (req_dev_addr),
        .req_rw       (req_rw),
        .req_reg_addr (req_reg_addr),
        .req_wdata    (req_wdata),
        .gnt          (gnt),
        .done         (done),
        .err          (err),
        .rdata        (rdata),
        .i2c_dev_addr (i2c_dev_addr),
        .i2c_reg_addr (i2c_reg_addr),
        .i2c_wdata    (i2c_wdata),
        .i2c_rdata    (i2c_rdata),
        .i2c_we       (i2c_we),
        .i2c_status   (i2c_status)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [1:0] st;
        logic       we;
        logic [7:0] rd;
        logic [3:0] e_gnt;
        logic [3:0] e_done;
        logic       e_err;
        logic [8:0] e_dev;
        logic [7:0] e_rdata;
    } vec_t;

    vec_t vecs [11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("[TB] ok %s = 0x%0h", name, act);
        end
    endtask

    task automatic set_fields();
        req_dev_addr = {7'h00, 7'h48, 7'h00, 7'h50};
        req_rw       = 4'b0001;
        req_reg_addr = {8'h00, 8'h10, 8'h00, 8'h22};
        req_wdata    = {8'h00, 8'hA5, 8'h00, 8'h00};
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    int      order_exp [5] = '{1, 2, 4, 8, 1};
    int      waited;
    int      hit;

    initial begin
        reset = 1'b0; req = '0; i2c_rdata = '0; i2c_we = 1'b0; i2c_status = 2'b00;
        set_fields();

        // write to requester 2, then read from requester 0
        vecs[0]  = '{4'b0100, 2'b00, 1'b0, 8'h00, 4'b0100, 4'b0000, 1'b0, 9'h190, 8'h00};
        vecs[1]  = '{4'b0100, 2'b00, 1'b0, 8'h00, 4'b0100, 4'b0000, 1'b0, 9'h190, 8'h00};
        vecs[2]  = '{4'b0100, 2'b01, 1'b0, 8'h00, 4'b0100, 4'b0000, 1'b0, 9'h090, 8'h00};
        vecs[3]  = '{4'b0100, 2'b01, 1'b0, 8'h00, 4'b0100, 4'b0000, 1'b0, 9'h090, 8'h00};
        vecs[4]  = '{4'b0100, 2'b10, 1'b0, 8'h00, 4'b0100, 4'b0100, 1'b0, 9'h090, 8'h00};
        vecs[5]  = '{4'b0000, 2'b00, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0, 9'h000, 8'h00};
        vecs[6]  = '{4'b0001, 2'b00, 1'b0, 8'h00, 4'b0001, 4'b0000, 1'b0, 9'h1A1, 8'h00};
        vecs[7]  = '{4'b0001, 2'b01, 1'b0, 8'h00, 4'b0001, 4'b0000, 1'b0, 9'h0A1, 8'h00};
        vecs[8]  = '{4'b0001, 2'b01, 1'b1, 8'h3C, 4'b0001, 4'b0000, 1'b0, 9'h0A1, 8'h3C};
        vecs[9]  = '{4'b0001, 2'b10, 1'b0, 8'h00, 4'b0001, 4'b0001, 1'b0, 9'h0A1, 8'h3C};
        vecs[10] = '{4'b0000, 2'b00, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0, 9'h000, 8'h3C};

        tick();
        tick();
        check("reset gnt", 32'(gnt), 32'h0);
        check("reset done", 32'(done), 32'h0);
        check("reset err", 32'(err), 32'h0);
        check("reset rdata", 32'(rdata), 32'h0);
        check("reset dev", 32'(i2c_dev_addr), 32'h0);
        check("reset reg", 32'(i2c_reg_addr), 32'h0);
        check("reset wdata", 32'(i2c_wdata), 32'h0);
        reset = 1'b1;

        for (int i = 0; i < 11; i++) begin
            req        = vecs[i].req;
            i2c_status = vecs[i].st;
            i2c_we     = vecs[i].we;
            i2c_rdata  = vecs[i].rd;
            tick();
            check($sformatf("row%0d gnt", i), 32'(gnt), 32'(vecs[i].e_gnt));
            check($sformatf("row%0d done", i), 32'(done), 32'(vecs[i].e_done));
            check($sformatf("row%0d err", i), 32'(err), 32'(vecs[i].e_err));
            check($sformatf("row%0d rdata", i), 32'(rdata), 32'(vecs[i].e_rdata));
            if (vecs[i].e_gnt != 0)
                check($sformatf("row%0d dev", i), 32'(i2c_dev_addr), 32'(vecs[i].e_dev));
            if (i == 1) begin
                check("write reg", 32'(i2c_reg_addr), 32'h10);
                check("write wdata", 32'(i2c_wdata), 32'hA5);
            end
        end
        i2c_we = 1'b0;

        // NACK on requester 1, then pointer must have moved past it
        req = 4'b0010; tick();
        check("nack gnt", 32'(gnt), 32'h2);
        i2c_status = 2'b01; tick();
        i2c_status = 2'b11; tick();
        check("nack done", 32'(done), 32'h2);
        check("nack err", 32'(err), 32'h1);
        i2c_status = 2'b00; req = 4'b0110; tick();
        check("nack release", 32'(gnt), 32'h0);
        tick();
        check("ptr after nack", 32'(gnt), 32'h4);
        i2c_status = 2'b01; tick();
        i2c_status = 2'b10; tick();
        check("post-nack done", 32'(done), 32'h4);
        check("post-nack err", 32'(err), 32'h0);
        req = 4'b0000; i2c_status = 2'b00; tick();

        // latched fields stable, dropped req still completes, late req ignored
        req = 4'b0100; tick();
        check("stab gnt", 32'(gnt), 32'h4);
        req_dev_addr = {4{7'h11}}; req_reg_addr = {4{8'hEE}};
        req_wdata = {4{8'h5A}}; req_rw = 4'b1111; req = 4'b1011;
        i2c_status = 2'b01; tick();
        check("stab gnt wait", 32'(gnt), 32'h4);
        check("stab dev", 32'(i2c_dev_addr[7:0]), 32'h90);
        check("stab reg", 32'(i2c_reg_addr), 32'h10);
        check("stab wdata", 32'(i2c_wdata), 32'hA5);
        i2c_status = 2'b10; tick();
        check("stab done", 32'(done), 32'h4);
        check("stab dev resp", 32'(i2c_dev_addr[7:0]), 32'h90);
        req = 4'b0000; i2c_status = 2'b00; tick();
        set_fields();

        // contention from reset pointer: 0,1,2,3,0
        do_reset();
        req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            waited = 0;
            tick();
            while (gnt == 0 && waited < 10) begin
                tick();
                waited++;
            end
            check($sformatf("rr grant %0d", t), 32'(gnt), 32'(order_exp[t]));
            i2c_status = 2'b01; tick();
            i2c_status = 2'b10; tick();
            check($sformatf("rr done %0d", t), 32'(done), 32'(order_exp[t]));
            i2c_status = 2'b00; tick();
        end
        req = 4'b0000; tick();

        // timeout with status stuck busy
        req = 4'b0001; tick();
        check("to gnt", 32'(gnt), 32'h1);
        i2c_status = 2'b01;
        hit = 0;
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (done != 0) begin
                hit = k;
                break;
            end
        end
        check("to latency", 32'(hit), 32'd16);
        check("to done", 32'(done), 32'h1);
        check("to err", 32'(err), 32'h1);
        check("to go", 32'(i2c_dev_addr[8]), 32'h0);
        req = 4'b0000; i2c_status = 2'b00; tick();

        // reset while in WAIT abandons the transaction
        req = 4'b0001; tick();
        i2c_status = 2'b01; i2c_we = 1'b1; i2c_rdata = 8'h77; tick();
        i2c_we = 1'b0;
        check("rw rdata", 32'(rdata), 32'h77);
        reset = 1'b0; tick();
        check("rw gnt", 32'(gnt), 32'h0);
        check("rw done", 32'(done), 32'h0);
        check("rw err", 32'(err), 32'h0);
        check("rw rdata0", 32'(rdata), 32'h0);
        check("rw dev", 32'(i2c_dev_addr), 32'h0);
        check("rw reg", 32'(i2c_reg_addr), 32'h0);
        check("rw wdata", 32'(i2c_wdata), 32'h0);
        reset = 1'b1; req = 4'b0000; i2c_status = 2'b10; tick();
        check("rw no done", 32'(done), 32'h0);
        i2c_status = 2'b00; req = 4'b1111; tick();
        check("rw idle ptr0", 32'(gnt), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
